// File: rtl/pmem_dpi_pkg.sv
// pmem_dpi_pkg: simulation-side implementation of the physical-memory
// access functions v_pmem_read / v_pmem_write that the responder calls.
// Storage is a sparse word map; words never written read as zero. Call
// counters and the last write mask are kept so the environment can observe
// how many accesses were made.
//   v_pmem_read(addr)               returns the word at addr
//   v_pmem_write(addr, wdata, mask) byte-merges wdata into the word at addr
package pmem_dpi_pkg;

  logic [31:0] mem [logic [31:0]];
  int unsigned read_calls  = 0;
  int unsigned write_calls = 0;
  logic [7:0]  last_wmask  = 8'h00;

  function automatic logic [31:0] v_pmem_read(input logic [31:0] addr);
    logic [31:0] key;
    key = addr & 32'hFFFF_FFFC;
    read_calls++;
    return mem.exists(key) ? mem[key] : 32'h0;
  endfunction

  function automatic void v_pmem_write(input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       input logic [7:0]  wmask);
    logic [31:0] key;
    logic [31:0] word;
    key = addr & 32'hFFFF_FFFC;
    write_calls++;
    last_wmask = wmask;
    word = mem.exists(key) ? mem[key] : 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
    end
    mem[key] = word;
  endfunction

endpackage

// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types, constants and the address-fault check used by
// the pmem_responder block.
//   state_e          responder FSM states (IDLE, BUSY, RESP)
//   WORD_ALIGN_MASK  low address bits that must be zero for a word access
//   WMASK_EXT_W      zero bits prepended to the 4-bit byte mask for the
//                    8-bit mask argument of v_pmem_write
//   addr_fault()     1 when an address is misaligned or outside [base, base+size)
package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;
  localparam int          WMASK_EXT_W     = 4;

  // The window test subtracts first and compares the offset unsigned, so a
  // window that ends exactly at 2^32 never needs a 33-bit upper bound.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
    logic [31:0] offset;
    offset = addr - base;
    return ((addr & WORD_ALIGN_MASK) != 32'h0) || (addr < base) || (offset >= size);
  endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// pmem_responder_if: load/store request and response channels between the
// core (master) and the memory responder (slave).
//   req_valid/req_ready   request handshake
//   req_wen               1 = write, 0 = read
//   req_addr/req_wdata    byte address and write data
//   req_wmask             byte enables for writes
//   resp_valid/resp_ready response handshake
//   resp_rdata/resp_err   read data (0 for writes and faults) and fault flag
interface pmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/pmem_lat_counter.sv
// pmem_lat_counter: 4-bit loadable down-counter that times the BUSY phase.
//   clk, rst   clock and asynchronous active-high reset
//   load       load load_val (has priority over en)
//   en         decrement by one while nonzero
//   load_val   value loaded on load
//   zero       count is zero
module pmem_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: memory-side responder for the core load/store port.
// Accepts one request at a time, spends LATENCY cycles in BUSY, performs
// the access through v_pmem_read / v_pmem_write on the last BUSY edge and
// holds the response until the requester takes it.
//   clk, rst   clock and asynchronous active-high reset
//   bus        pmem_responder_if.slave (request and response channels)
// Parameters: LATENCY (1..15) BUSY cycles, BASE/SIZE legal address window.
module pmem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter logic [31:0] SIZE    = 32'h0800_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  pmem_responder_if.slave        bus
);

  import pmem_pkg::*;

  // Loading LATENCY-1 and acting on the zero edge yields exactly LATENCY
  // cycles in BUSY.
  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

  state_e      state;
  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        cnt_load;
  logic        cnt_en;
  logic        cnt_zero;
  logic        acc_fault;

  assign cnt_load  = (state == IDLE) && bus.req_valid;
  assign cnt_en    = (state == BUSY);
  assign acc_fault = addr_fault(lat_addr, BASE, SIZE);

  pmem_lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  // The memory functions are called only here, on the single edge that
  // leaves BUSY, so each accepted transaction makes at most one call and a
  // reset (which takes priority) drops the access entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_wen      <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_wmask    <= 4'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_wen     <= bus.req_wen;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            lat_wmask   <= bus.req_wmask;
            req_ready_q <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_zero) begin
            resp_valid_q <= 1'b1;
            state        <= RESP;
            if (acc_fault) begin
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b1;
            end else if (!lat_wen) begin
              resp_rdata_q <= pmem_dpi_pkg::v_pmem_read(lat_addr);
              resp_err_q   <= 1'b0;
            end else begin
              if (lat_wmask != 4'h0) begin
                pmem_dpi_pkg::v_pmem_write(lat_addr, lat_wdata,
                                           {{WMASK_EXT_W{1'b0}}, lat_wmask});
              end
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b0;
            end
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: self-checking bench for pmem_responder. A
// transaction-level model (timestamps plus a word map) predicts the
// LATENCY=2 instance's outputs every cycle; directed sequences pin
// latencies, data values, fault flags and memory-call counts. A second
// instance with LATENCY=1 covers the shortest latency.
module tb_pmem_responder;

  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0800_0000;

  localparam logic [31:0] F_ADDR [4] = '{32'h8000_0002, 32'h7FFF_FFFC,
                                         32'h8800_0000, 32'h87FF_FFFC};
  localparam logic [31:0] F_ERR  [4] = '{32'd1, 32'd1, 32'd1, 32'd0};
  localparam logic [31:0] F_RD   [4] = '{32'd0, 32'd0, 32'd0, 32'd1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_responder_if bus ();
  pmem_responder_if bus1 ();

  pmem_responder #(.LATENCY(LAT), .BASE(BASE), .SIZE(SIZE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pmem_responder #(.LATENCY(1), .BASE(BASE), .SIZE(SIZE)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (LATENCY=2 instance) ----------------
  logic [31:0] mdl_mem [logic [31:0]];
  int unsigned edge_n      = 0;
  int unsigned m_acc_edge  = 0;
  bit          m_pending   = 1'b0;
  bit          m_have_resp = 1'b0;
  bit          m_wen       = 1'b0;
  logic [31:0] m_addr      = 32'h0;
  logic [31:0] m_wdata     = 32'h0;
  logic [3:0]  m_wmask     = 4'h0;
  logic [31:0] m_rdata     = 32'h0;
  logic        m_err       = 1'b0;

  function automatic bit mdl_fault(input logic [31:0] a);
    longint unsigned lo, hi, av;
    lo = BASE;
    hi = lo + SIZE;
    av = a;
    return (av % 4 != 0) || (av < lo) || (av >= hi);
  endfunction

  function automatic logic [32:0] mdl_access(input bit wen, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] cur;
    if (mdl_fault(a)) return {1'b1, 32'h0};
    cur = mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
    if (!wen) return {1'b0, cur};
    for (int i = 0; i < 4; i++) begin
      if (wm[i]) cur[8*i +: 8] = wd[8*i +: 8];
    end
    mdl_mem[a] = cur;
    return {1'b0, 32'h0};
  endfunction

  // Accept at edge A; access at edge A+LAT; retire on the first later edge
  // that sees resp_ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending   <= 1'b0;
      m_have_resp <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (m_have_resp) begin
        if (bus.resp_ready) begin
          m_pending   <= 1'b0;
          m_have_resp <= 1'b0;
        end
      end else if (m_pending) begin
        if (edge_n + 1 == m_acc_edge + LAT) begin
          {m_err, m_rdata} <= mdl_access(m_wen, m_addr, m_wdata, m_wmask);
          m_have_resp      <= 1'b1;
        end
      end else if (bus.req_valid) begin
        m_pending  <= 1'b1;
        m_acc_edge <= edge_n + 1;
        m_wen      <= bus.req_wen;
        m_addr     <= bus.req_addr;
        m_wdata    <= bus.req_wdata;
        m_wmask    <= bus.req_wmask;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      check("cyc req_ready",  32'(bus.req_ready),  32'(!m_pending));
      check("cyc resp_valid", 32'(bus.resp_valid), 32'(m_have_resp));
      check("cyc resp_rdata", bus.resp_rdata,      m_have_resp ? m_rdata : 32'h0);
      check("cyc resp_err",   32'(bus.resp_err),   32'(m_have_resp && m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  // Drives a request just after a falling edge, so it is accepted on the
  // next rising edge; lat counts rising edges from accept to resp_valid.
  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int stall,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_wmask = 4'h0;
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall resp_valid", 32'(bus.resp_valid), 32'd1);
      check("stall resp_rdata", bus.resp_rdata, rdata);
      check("stall req_ready",  32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("retire resp_valid", 32'(bus.resp_valid), 32'd0);
    check("retire req_ready",  32'(bus.req_ready),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned r0, w0;

    rst = 1'b1;
    bus.req_valid  = 1'b0; bus.req_wen  = 1'b0; bus.req_addr  = 32'h0;
    bus.req_wdata  = 32'h0; bus.req_wmask = 4'h0; bus.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_wen = 1'b0; bus1.req_addr = 32'h0;
    bus1.req_wdata = 32'h0; bus1.req_wmask = 4'h0; bus1.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);
    check("reset req_ready",  32'(bus.req_ready),  32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_rdata", bus.resp_rdata,      32'h0);
    check("reset resp_err",   32'(bus.resp_err),   32'd0);

    // Preload through the write path with full masks.
    do_txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    do_txn(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 0, rd, er, lat);
    do_txn(1'b1, 32'h8000_0030, 32'h1234_5678, 4'hF, 0, rd, er, lat);

    // Plain read: response after exactly LAT BUSY cycles.
    r0 = pmem_dpi_pkg::read_calls;
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check("read latency", 32'(lat), 32'd2);
    check("read rdata",   rd,       32'hDEAD_BEEF);
    check("read err",     32'(er),  32'd0);
    check("read calls",   32'(pmem_dpi_pkg::read_calls - r0), 32'd1);

    // Partial write then read back.
    w0 = pmem_dpi_pkg::write_calls;
    do_txn(1'b1, 32'h8000_0020, 32'h1122_3344, 4'b0011, 0, rd, er, lat);
    check("pwrite calls", 32'(pmem_dpi_pkg::write_calls - w0), 32'd1);
    check("pwrite mask",  32'(pmem_dpi_pkg::last_wmask), 32'h03);
    check("pwrite rdata", rd, 32'h0);
    check("pwrite err",   32'(er), 32'd0);
    do_txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
    check("readback", rd, 32'hAABB_3344);

    // Alignment and window faults.
    for (int i = 0; i < 4; i++) begin
      r0 = pmem_dpi_pkg::read_calls;
      do_txn(1'b0, F_ADDR[i], 32'h0, 4'h0, 0, rd, er, lat);
      check("fault err",   32'(er), F_ERR[i]);
      check("fault rdata", rd,      32'h0);
      check("fault calls", 32'(pmem_dpi_pkg::read_calls - r0), F_RD[i]);
    end

    // Backpressure: five stalled cycles in RESP.
    r0 = pmem_dpi_pkg::read_calls;
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, rd, er, lat);
    check("stall rdata", rd, 32'hDEAD_BEEF);
    check("stall calls", 32'(pmem_dpi_pkg::read_calls - r0), 32'd1);

    // Zero-mask write: no call, no fault, memory unchanged.
    w0 = pmem_dpi_pkg::write_calls;
    do_txn(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
    check("wmask0 err",   32'(er), 32'd0);
    check("wmask0 calls", 32'(pmem_dpi_pkg::write_calls - w0), 32'd0);
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check("wmask0 readback", rd, 32'hDEAD_BEEF);

    // Reset during BUSY of a write drops it.
    w0 = pmem_dpi_pkg::write_calls;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 32'h8000_0030;
    bus.req_wdata = 32'h0000_0055; bus.req_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_wmask = 4'h0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstmid req_ready",  32'(bus.req_ready),  32'd1);
    check("rstmid calls",      32'(pmem_dpi_pkg::write_calls - w0), 32'd0);
    do_txn(1'b0, 32'h8000_0030, 32'h0, 4'h0, 0, rd, er, lat);
    check("rstmid readback", rd, 32'h1234_5678);

    // LATENCY=1 instance: a single BUSY cycle.
    r0 = pmem_dpi_pkg::read_calls;
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_wen = 1'b0; bus1.req_addr = 32'h8000_0030;
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0; bus1.req_addr = 32'h0;
    check("lat1 busy resp_valid", 32'(bus1.resp_valid), 32'd0);
    lat = 0;
    while (!bus1.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("lat1 latency", 32'(lat), 32'd1);
    check("lat1 rdata",   bus1.resp_rdata, 32'h1234_5678);
    check("lat1 err",     32'(bus1.resp_err), 32'd0);
    check("lat1 calls",   32'(pmem_dpi_pkg::read_calls - r0), 32'd1);
    bus1.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.resp_ready = 1'b0;
    check("lat1 retire", 32'(bus1.resp_valid), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
